// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared types and constants for the stopwatch/countdown timer.
// Contents:
//   state_e    - control FSM state encoding
//   DIGIT_MAX  - largest value of a decimal BCD digit
//   TENS_MAX   - largest value of the tens-of-seconds digit
//   bcd_clamp  - saturate a BCD digit at a given limit
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit, input logic [3:0] limit);
        return (digit > limit) ? limit : digit;
    endfunction

endpackage

// File: rtl/stopwatch_prescaler.sv
// stopwatch_prescaler
// Divides clk down to one tick per TICK_DIV enabled cycles. The count is
// held while en is low, so a partially elapsed tenth survives a pause.
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   en       in   advance the count this cycle
//   sync_clr in   synchronous clear of the count (wins over en)
//   tick     out  high while enabled and the count sits at TICK_DIV-1
module stopwatch_prescaler #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (sync_clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// stopwatch_timer
// BCD mm:ss.t counter that runs either as a count-up stopwatch or as a
// preset countdown timer, with start/stop/clear/load control.
// Optional build macro: STOPWATCH_LAP_HOLD_EN adds a lap input that freezes
// the displayed digits while the count keeps running.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start, stop, clear, load     control (priority clear > load > stop > start)
//   countdown                    mode select, latched on start
//   lap                          (STOPWATCH_LAP_HOLD_EN only) toggle display hold
//   preset_*                     BCD preset digits, clamped on load
//   minutes..tenths_seconds      BCD display digits
//   running, expired             state decodes
//   tick, overflow               one-cycle pulses
//
// state   | meaning
// IDLE    | stopped, digits cleared or preset, waiting for start
// RUN     | prescaler running, digits advance once per tick
// PAUSED  | stopped mid-count, prescaler phase retained
// EXPIRED | countdown reached 0:00.0, only clear/load/reset leave
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 10_000_000,
    parameter int MIN_DIGITS = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    countdown,
    input  logic                    load,
`ifdef STOPWATCH_LAP_HOLD_EN
    input  logic                    lap,
`endif
    input  logic [4*MIN_DIGITS-1:0] preset_minutes,
    input  logic [3:0]              preset_tens,
    input  logic [3:0]              preset_ones,
    input  logic [3:0]              preset_tenths,
    output logic [4*MIN_DIGITS-1:0] minutes,
    output logic [3:0]              tens_seconds,
    output logic [3:0]              ones_seconds,
    output logic [3:0]              tenths_seconds,
    output logic                    running,
    output logic                    tick,
    output logic                    overflow,
    output logic                    expired
);

    localparam int MW = 4 * MIN_DIGITS;
    localparam int DW = MW + 12;

    state_e          state_q;
    logic            mode_q;
    logic [MW-1:0]   min_q;
    logic [3:0]      tens_q;
    logic [3:0]      ones_q;
    logic [3:0]      tenths_q;
    logic            ovf_q;

    logic            tick_w;
    logic            load_acc;
    logic            live_zero;

    logic [MW-1:0]   min_up;
    logic [3:0]      tens_up;
    logic [3:0]      ones_up;
    logic [3:0]      tenths_up;
    logic            up_wrap;

    logic [MW-1:0]   min_dn;
    logic [3:0]      tens_dn;
    logic [3:0]      ones_dn;
    logic [3:0]      tenths_dn;
    logic            dn_zero;

    logic [MW-1:0]   min_clamped;
    logic [DW-1:0]   live_digits;
    logic [DW-1:0]   disp_digits;

    assign load_acc  = load && (state_q != RUN);
    assign live_zero = (min_q == '0) && (tens_q == 4'd0) && (ones_q == 4'd0)
                       && (tenths_q == 4'd0);

    stopwatch_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (state_q == RUN),
        .sync_clr (clear || load_acc),
        .tick     (tick_w)
    );

    // Increment with BCD carry ripple; carry out of the top minute digit
    // means the counter wrapped from its maximum back to zero.
    always_comb begin
        logic carry;
        carry     = (tenths_q == DIGIT_MAX);
        tenths_up = carry ? 4'd0 : tenths_q + 4'd1;
        ones_up   = ones_q;
        if (carry) ones_up = (ones_q == DIGIT_MAX) ? 4'd0 : ones_q + 4'd1;
        carry     = carry && (ones_q == DIGIT_MAX);
        tens_up   = tens_q;
        if (carry) tens_up = (tens_q == TENS_MAX) ? 4'd0 : tens_q + 4'd1;
        carry     = carry && (tens_q == TENS_MAX);
        min_up    = min_q;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (carry) begin
                if (min_q[4*i +: 4] == DIGIT_MAX) begin
                    min_up[4*i +: 4] = 4'd0;
                end else begin
                    min_up[4*i +: 4] = min_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        up_wrap = carry;
    end

    // Decrement with BCD borrow ripple; a borrow out of the top digit means
    // the count was already zero, in which case it saturates at zero.
    always_comb begin
        logic borrow;
        borrow    = (tenths_q == 4'd0);
        tenths_dn = borrow ? DIGIT_MAX : tenths_q - 4'd1;
        ones_dn   = ones_q;
        if (borrow) ones_dn = (ones_q == 4'd0) ? DIGIT_MAX : ones_q - 4'd1;
        borrow    = borrow && (ones_q == 4'd0);
        tens_dn   = tens_q;
        if (borrow) tens_dn = (tens_q == 4'd0) ? TENS_MAX : tens_q - 4'd1;
        borrow    = borrow && (tens_q == 4'd0);
        min_dn    = min_q;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (borrow) begin
                if (min_q[4*i +: 4] == 4'd0) begin
                    min_dn[4*i +: 4] = DIGIT_MAX;
                end else begin
                    min_dn[4*i +: 4] = min_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        if (borrow) begin
            min_dn    = '0;
            tens_dn   = 4'd0;
            ones_dn   = 4'd0;
            tenths_dn = 4'd0;
        end
        dn_zero = (min_dn == '0) && (tens_dn == 4'd0) && (ones_dn == 4'd0)
                  && (tenths_dn == 4'd0);
    end

    always_comb begin
        min_clamped = '0;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            min_clamped[4*i +: 4] = bcd_clamp(preset_minutes[4*i +: 4], DIGIT_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            min_q    <= '0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            tenths_q <= 4'd0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (clear) begin
                state_q  <= IDLE;
                min_q    <= '0;
                tens_q   <= 4'd0;
                ones_q   <= 4'd0;
                tenths_q <= 4'd0;
            end else if (load_acc) begin
                state_q  <= IDLE;
                min_q    <= min_clamped;
                tens_q   <= bcd_clamp(preset_tens, TENS_MAX);
                ones_q   <= bcd_clamp(preset_ones, DIGIT_MAX);
                tenths_q <= bcd_clamp(preset_tenths, DIGIT_MAX);
            end else begin
                unique case (state_q)
                    IDLE: begin
                        // A countdown from zero would expire immediately; refuse it.
                        if (start && !stop && !(countdown && live_zero)) begin
                            state_q <= RUN;
                            mode_q  <= countdown;
                        end
                    end
                    PAUSED: begin
                        if (start && !stop) begin
                            state_q <= RUN;
                            mode_q  <= countdown;
                        end
                    end
                    RUN: begin
                        if (tick_w) begin
                            if (mode_q) begin
                                min_q    <= min_dn;
                                tens_q   <= tens_dn;
                                ones_q   <= ones_dn;
                                tenths_q <= tenths_dn;
                            end else begin
                                min_q    <= min_up;
                                tens_q   <= tens_up;
                                ones_q   <= ones_up;
                                tenths_q <= tenths_up;
                                ovf_q    <= up_wrap;
                            end
                        end
                        // Expiry takes precedence over a coincident stop.
                        if (tick_w && mode_q && dn_zero) begin
                            state_q <= EXPIRED;
                        end else if (stop) begin
                            state_q <= PAUSED;
                        end
                    end
                    EXPIRED: begin
                        state_q <= EXPIRED;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign live_digits = {min_q, tens_q, ones_q, tenths_q};

`ifdef STOPWATCH_LAP_HOLD_EN
    logic [DW-1:0] hold_q;
    logic          hold_act_q;

    // The hold only has meaning while running; leaving RUN drops it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q     <= '0;
            hold_act_q <= 1'b0;
        end else if (clear || stop || (state_q != RUN)) begin
            hold_act_q <= 1'b0;
        end else if (lap) begin
            if (hold_act_q) begin
                hold_act_q <= 1'b0;
            end else begin
                hold_act_q <= 1'b1;
                hold_q     <= live_digits;
            end
        end
    end

    assign disp_digits = (hold_act_q && (state_q == RUN)) ? hold_q : live_digits;
`else
    assign disp_digits = live_digits;
`endif

    assign minutes        = disp_digits[DW-1:12];
    assign tens_seconds   = disp_digits[11:8];
    assign ones_seconds   = disp_digits[7:4];
    assign tenths_seconds = disp_digits[3:0];

    assign running  = (state_q == RUN);
    assign expired  = (state_q == EXPIRED);
    assign tick     = tick_w;
    assign overflow = ovf_q;

endmodule
